registers: RTL and testbench
============================

REGISTERS -- requirements
Module: registers

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of each register and of every data port.
REQ-002 Parameter ADDR_WIDTH, default 5, width of every register-address port.
REQ-003 Parameter NUM_REGS, default 2**ADDR_WIDTH (32), number of registers.
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 clk  input  1  clock; all state changes on rising edge.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 readRegister1  input  ADDR_WIDTH  address for read port 1.
REQ-008 readRegister2  input  ADDR_WIDTH  address for read port 2.
REQ-009 writeRegister  input  ADDR_WIDTH  address for the write port.
REQ-010 writeData  input  DATA_WIDTH  data to write.
REQ-011 regWrite  input  1  write enable.
REQ-012 readData1  output  DATA_WIDTH  contents of readRegister1.
REQ-013 readData2  output  DATA_WIDTH  contents of readRegister2.

Function
REQ-014 Storage: NUM_REGS registers of DATA_WIDTH bits, indexed 0..NUM_REGS-1.
REQ-015 Write: on rising clk with regWrite=1 and reset=0, register[writeRegister] <= writeData; no other register changes.
REQ-016 regWrite=0: no register changes on any edge.
REQ-017 Register 0 is an ordinary writable register (not hardwired to zero).
REQ-018 Reads are combinational: readDataN = register[readRegisterN], zero-cycle latency, updates immediately on address change.
REQ-019 Both read ports are independent; both may address the same register, including the register being written.
REQ-020 Without bypass (see Configuration), a read of the register being written returns the old value until the edge, the new value immediately after.
REQ-021 Write data is truncated/held exactly at DATA_WIDTH; no sign or width conversion.
REQ-022 Simultaneous reset=1 and regWrite=1 on the same edge: reset wins, no write.

Reset
REQ-023 On rising clk with reset=1, all NUM_REGS registers become 0.
REQ-024 After reset, readData1 and readData2 are 0 for any address.
REQ-025 Before the first reset, register contents are undefined; no initial values are required except register 0, which powers up at 0.

Configuration
REQ-026 Macro REGISTERS_WRITE_BYPASS_EN defined: when regWrite=1, reset=0 and readRegisterN == writeRegister, readDataN = writeData combinationally (write-through before the edge).
REQ-027 Macro undefined: no bypass; behaviour per REQ-020.

Structure
REQ-028 Package registers_pkg holds DATA_WIDTH/ADDR_WIDTH default constants and a register-word typedef.
REQ-029 One sub-module registers_read_port (address mux plus optional bypass compare), instantiated twice.

Verification
REQ-030 reset=1 one edge, then read addr 0 and 1 -> readData1=0, readData2=0.
REQ-031 Write reg0=32'd1 then reg1=32'd1 (regWrite=1, one edge each), read 0/1 -> readData1=1, readData2=1.
REQ-032 regWrite=0, writeRegister=5, writeData=32'hDEADBEEF, one edge -> reg5 reads 0.
REQ-033 Write reg31=32'hFFFFFFFF, read both ports at 31 -> both 32'hFFFFFFFF; reg30 still 0.
REQ-034 reset=1 and regWrite=1 (reg3=32'h12345678) same edge -> reg3 reads 0.
REQ-035 regWrite=1 writeRegister=7 writeData=32'hA5A5A5A5, readRegister1=7 before edge -> old value (0) without macro, 32'hA5A5A5A5 with REGISTERS_WRITE_BYPASS_EN; after edge 32'hA5A5A5A5 in both builds.

Source files
------------

// File: rtl/registers_pkg.sv
// Shared widths and word type for the register file.
// Optional write bypass: define REGISTERS_WRITE_BYPASS_EN.
package registers_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 5;
    localparam int DEF_NUM_REGS   = 2 ** DEF_ADDR_WIDTH;

    typedef logic [DEF_DATA_WIDTH-1:0] reg_word_t;
    typedef logic [DEF_ADDR_WIDTH-1:0] reg_addr_t;

    // True when a write this cycle targets the given read address.
    function automatic logic addr_match(
        input logic [DEF_ADDR_WIDTH-1:0] a,
        input logic [DEF_ADDR_WIDTH-1:0] b,
        input logic                      en
    );
        return en && (a == b);
    endfunction

endpackage

// File: rtl/registers_read_port.sv
// One combinational read port: address mux with optional write bypass.
// Bypass compare is built only when REGISTERS_WRITE_BYPASS_EN is defined.
module registers_read_port
    import registers_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int NUM_REGS   = 2 ** ADDR_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] i_regs [NUM_REGS],
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_wr_en,
    output logic [DATA_WIDTH-1:0] o_data
);

    logic [DATA_WIDTH-1:0] w_sel;

    // Addresses beyond NUM_REGS read as zero.
    always_comb begin
        w_sel = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (i_addr == ADDR_WIDTH'(i)) begin
                w_sel = i_regs[i];
            end
        end
    end

`ifdef REGISTERS_WRITE_BYPASS_EN
    logic w_hit;

    assign w_hit  = i_wr_en && (i_wr_addr == i_addr);
    assign o_data = w_hit ? i_wr_data : w_sel;
`else
    logic w_unused;

    assign w_unused = ^{i_wr_addr, i_wr_data, i_wr_en};
    assign o_data   = w_sel;
`endif

endmodule

// File: rtl/registers.sv
// Two-read, one-write register file with synchronous active-high reset.
// Optional write-through bypass: define REGISTERS_WRITE_BYPASS_EN.
module registers
    import registers_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int NUM_REGS   = 2 ** ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] readRegister1,
    input  logic [ADDR_WIDTH-1:0] readRegister2,
    input  logic [ADDR_WIDTH-1:0] writeRegister,
    input  logic [DATA_WIDTH-1:0] writeData,
    input  logic                  regWrite,
    output logic [DATA_WIDTH-1:0] readData1,
    output logic [DATA_WIDTH-1:0] readData2
);

    logic [DATA_WIDTH-1:0] w_regs [NUM_REGS];
    logic                  w_wr_en;

    // Reset takes priority over a same-edge write.
    assign w_wr_en = regWrite && !reset;

    // Register 0 must power up at zero even before the first reset.
    logic [DATA_WIDTH-1:0] r_reg0 = '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_reg0 <= '0;
        end else if (w_wr_en && writeRegister == '0) begin
            r_reg0 <= writeData;
        end
    end

    assign w_regs[0] = r_reg0;

    for (genvar g = 1; g < NUM_REGS; g++) begin : g_reg
        logic [DATA_WIDTH-1:0] r_q;
        logic                  w_we;

        assign w_we = w_wr_en && (writeRegister == ADDR_WIDTH'(g));

        always_ff @(posedge clk) begin
            if (reset) begin
                r_q <= '0;
            end else if (w_we) begin
                r_q <= writeData;
            end
        end

        assign w_regs[g] = r_q;
    end

    registers_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_REGS   (NUM_REGS)
    ) u_rd1 (
        .i_regs    (w_regs),
        .i_addr    (readRegister1),
        .i_wr_addr (writeRegister),
        .i_wr_data (writeData),
        .i_wr_en   (w_wr_en),
        .o_data    (readData1)
    );

    registers_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_REGS   (NUM_REGS)
    ) u_rd2 (
        .i_regs    (w_regs),
        .i_addr    (readRegister2),
        .i_wr_addr (writeRegister),
        .i_wr_data (writeData),
        .i_wr_en   (w_wr_en),
        .o_data    (readData2)
    );

endmodule

// File: tb/tb_registers.sv
// Self-checking bench for the register file against an array model.
// Build with REGISTERS_WRITE_BYPASS_EN to check the bypass variant.
module tb_registers;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 32;

`ifdef REGISTERS_WRITE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [AW-1:0] readRegister1 = '0;
    logic [AW-1:0] readRegister2 = '0;
    logic [AW-1:0] writeRegister = '0;
    logic [DW-1:0] writeData = '0;
    logic          regWrite = 1'b0;
    logic [DW-1:0] readData1;
    logic [DW-1:0] readData2;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] m_regs [NR];

    registers dut (
        .clk           (clk),
        .reset         (reset),
        .readRegister1 (readRegister1),
        .readRegister2 (readRegister2),
        .writeRegister (writeRegister),
        .writeData     (writeData),
        .regWrite      (regWrite),
        .readData1     (readData1),
        .readData2     (readData2)
    );

    always #5 clk = ~clk;

    // Value a read port should show right now, given pending inputs.
    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
        if (BYP && regWrite && !reset && a == writeRegister)
            return writeData;
        return m_regs[a];
    endfunction

    // One clock edge; model applies the architectural rule.
    task automatic step();
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < NR; i++) m_regs[i] = '0;
        end else if (regWrite) begin
            m_regs[writeRegister] = writeData;
        end
        #1;
    endtask

    task automatic write_reg(input logic [AW-1:0] a, input logic [DW-1:0] d);
        regWrite = 1'b1;
        writeRegister = a;
        writeData = d;
        step();
        regWrite = 1'b0;
    endtask

    task automatic test_powerup();
        readRegister1 = '0;
        #1;
        total++;
        if (readData1 !== '0) begin
            $display("FAIL powerup_reg0 got=%h exp=%h", readData1, 32'h0);
            bad++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < NR; i++) begin
            readRegister1 = AW'(i);
            readRegister2 = AW'(NR - 1 - i);
            #1;
            total++;
            if (readData1 !== '0 || readData2 !== '0) begin
                $display("FAIL reset_zero a=%0d got=%h/%h exp=0/0",
                         i, readData1, readData2);
                bad++;
            end
        end
    endtask

    task automatic test_write_basic();
        write_reg(5'd0, 32'd1);
        write_reg(5'd1, 32'd1);
        readRegister1 = 5'd0;
        readRegister2 = 5'd1;
        #1;
        total++;
        if (readData1 !== 32'd1 || readData2 !== 32'd1) begin
            $display("FAIL write_basic got=%h/%h exp=1/1",
                     readData1, readData2);
            bad++;
        end
    endtask

    task automatic test_no_write();
        regWrite = 1'b0;
        writeRegister = 5'd5;
        writeData = 32'hDEADBEEF;
        step();
        readRegister1 = 5'd5;
        #1;
        total++;
        if (readData1 !== 32'h0) begin
            $display("FAIL no_write got=%h exp=%h", readData1, 32'h0);
            bad++;
        end
    endtask

    task automatic test_boundary();
        write_reg(5'd31, 32'hFFFFFFFF);
        readRegister1 = 5'd31;
        readRegister2 = 5'd31;
        #1;
        total++;
        if (readData1 !== 32'hFFFFFFFF || readData2 !== 32'hFFFFFFFF) begin
            $display("FAIL boundary31 got=%h/%h exp=ffffffff",
                     readData1, readData2);
            bad++;
        end
        readRegister2 = 5'd30;
        #1;
        total++;
        if (readData2 !== 32'h0) begin
            $display("FAIL boundary30 got=%h exp=%h", readData2, 32'h0);
            bad++;
        end
    endtask

    task automatic test_reset_priority();
        write_reg(5'd3, 32'h11111111);
        reset = 1'b1;
        regWrite = 1'b1;
        writeRegister = 5'd3;
        writeData = 32'h12345678;
        step();
        reset = 1'b0;
        regWrite = 1'b0;
        readRegister1 = 5'd3;
        #1;
        total++;
        if (readData1 !== 32'h0) begin
            $display("FAIL reset_priority got=%h exp=%h", readData1, 32'h0);
            bad++;
        end
    endtask

    task automatic test_write_read_same();
        logic [DW-1:0] pre;
        pre = BYP ? 32'hA5A5A5A5 : 32'h0;
        regWrite = 1'b1;
        writeRegister = 5'd7;
        writeData = 32'hA5A5A5A5;
        readRegister1 = 5'd7;
        readRegister2 = 5'd7;
        #1;
        total++;
        if (readData1 !== pre || readData2 !== pre) begin
            $display("FAIL same_pre got=%h/%h exp=%h",
                     readData1, readData2, pre);
            bad++;
        end
        step();
        regWrite = 1'b0;
        #1;
        total++;
        if (readData1 !== 32'hA5A5A5A5 || readData2 !== 32'hA5A5A5A5) begin
            $display("FAIL same_post got=%h/%h exp=a5a5a5a5",
                     readData1, readData2);
            bad++;
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 8; i < 16; i++) begin
            write_reg(AW'(i), DW'(32'h1000 + i));
            readRegister1 = AW'(i);
            readRegister2 = AW'(i - 1);
            #1;
            total++;
            if (readData1 !== m_regs[i] || readData2 !== m_regs[i-1]) begin
                $display("FAIL b2b a=%0d got=%h/%h exp=%h/%h", i,
                         readData1, readData2, m_regs[i], m_regs[i-1]);
                bad++;
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 39) == 0);
            regWrite = $urandom_range(0, 2) != 0;
            writeRegister = AW'($urandom);
            writeData = $urandom;
            readRegister1 = ($urandom_range(0, 3) == 0) ? writeRegister
                                                         : AW'($urandom);
            readRegister2 = AW'($urandom);
            #1;
            total++;
            if (readData1 !== exp_rd(readRegister1) ||
                readData2 !== exp_rd(readRegister2)) begin
                $display("FAIL rand_pre n=%0d got=%h/%h exp=%h/%h", n,
                         readData1, readData2,
                         exp_rd(readRegister1), exp_rd(readRegister2));
                bad++;
            end
            step();
            reset = 1'b0;
            regWrite = 1'b0;
            #1;
            total++;
            if (readData1 !== m_regs[readRegister1] ||
                readData2 !== m_regs[readRegister2]) begin
                $display("FAIL rand_post n=%0d got=%h/%h exp=%h/%h", n,
                         readData1, readData2,
                         m_regs[readRegister1], m_regs[readRegister2]);
                bad++;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < NR; i++) m_regs[i] = 'x;
        m_regs[0] = '0;
        test_powerup();
        @(negedge clk);
        test_reset();
        test_write_basic();
        test_no_write();
        test_boundary();
        test_reset_priority();
        test_write_read_same();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
